key_mode_ctrl: RTL and testbench

Front-panel key controller for the DDS wave generator. It synchronizes and debounces three raw active-low push-buttons and produces the control inputs consumed by the address/amplitude controller. Those inputs are a 2-bit `mode_cnt` and single-cycle `key_inc`/`key_dec` strobes. Holding an inc/dec key generates auto-repeat strobes.

---
 rtl/key_pkg.sv | 22 ++
 rtl/key_mode_ctrl_if.sv | 23 ++
 rtl/key_debounce.sv | 53 +++++
 rtl/key_mode_ctrl.sv | 115 +++++++++++
 tb/tb_key_mode_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// key_pkg: shared types and defaults for the front-panel key controller.
//   rep_state_t      - auto-repeat FSM state encoding
//   DEF_*_CYCLES     - default timing constants for a 50 MHz sys_clk
//   cnt_w()          - counter width for a cycle count (never below 1)
package key_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } rep_state_t;

    localparam int DEF_DEB_CYCLES    = 1_000_000;   // 20 ms
    localparam int DEF_HOLD_CYCLES   = 25_000_000;  // 500 ms
    localparam int DEF_REPEAT_CYCLES = 5_000_000;   // 100 ms

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_mode_ctrl_if.sv
// key_mode_ctrl_if: front-panel key bundle.
//   key_mode_n / key_up_n / key_down_n - raw active-low buttons (async)
//   mode_cnt                           - current mode 0..3
//   key_inc / key_dec                  - one-cycle strobes
//   master: the panel side (drives keys); slave: the controller.
interface key_mode_ctrl_if;
    logic       key_mode_n;
    logic       key_up_n;
    logic       key_down_n;
    logic [1:0] mode_cnt;
    logic       key_inc;
    logic       key_dec;

    modport master (
        output key_mode_n, key_up_n, key_down_n,
        input  mode_cnt, key_inc, key_dec
    );

    modport slave (
        input  key_mode_n, key_up_n, key_down_n,
        output mode_cnt, key_inc, key_dec
    );
endinterface

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchronizer + debouncer for one active-low key.
//   sys_clk, sys_rst_n - clock, async active-low reset
//   i_key_n            - raw key level (asynchronous)
//   o_stable           - debounced level (1 = released)
//   o_press            - one-cycle pulse on a debounced 1->0 transition
import key_pkg::*;

module key_debounce #(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_key_n,
    output logic o_stable,
    output logic o_press
);

    localparam int             CW       = cnt_w(DEB_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1, r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                // Accept the new level; old level 1 means this is a press.
                r_stable <= r_sync2;
                r_cnt    <= '0;
                r_press  <= r_stable;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_press  = r_press;

endmodule

// File: rtl/key_mode_ctrl.sv
// key_mode_ctrl: front-panel key controller for the DDS wave generator.
//   sys_clk, sys_rst_n - 50 MHz clock, async active-low reset
//   bus (slave)        - raw keys in; mode_cnt, key_inc, key_dec out
// Mode presses step mode_cnt modulo 4. Up/down presses strobe key_inc /
// key_dec, with auto-repeat while held. Both held, or a mode press,
// locks the repeat FSMs until each key is released.
import key_pkg::*;

module key_mode_ctrl #(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    key_mode_ctrl_if.slave bus
);

    localparam int            TW        = cnt_w((HOLD_CYCLES > REPEAT_CYCLES) ?
                                                HOLD_CYCLES : REPEAT_CYCLES);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

    // bit 0 = mode, 1 = up, 2 = down
    logic [2:0] w_raw_n;
    logic [2:0] w_stable;
    logic [2:0] w_press;
    logic       w_mode_press;
    logic       w_lock_all;
    logic [1:0] w_fire;
    logic [1:0] r_mode_cnt;

    assign w_raw_n = {bus.key_down_n, bus.key_up_n, bus.key_mode_n};

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb[2:0] (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_key_n   (w_raw_n),
        .o_stable  (w_stable),
        .o_press   (w_press)
    );

    assign w_mode_press = w_press[0] & ~w_stable[0];
    // A mode press or both inc/dec held cancels all repeat activity.
    assign w_lock_all   = w_mode_press | (~w_stable[1] & ~w_stable[2]);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            r_mode_cnt <= 2'd0;
        else if (w_mode_press)
            r_mode_cnt <= r_mode_cnt + 2'd1;
    end

    // g = 0: up/inc, g = 1: down/dec
    for (genvar g = 0; g < 2; g++) begin : g_rep
        rep_state_t    r_state;
        logic [TW-1:0] r_timer;
        logic          r_fire;

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                r_state <= IDLE;
                r_timer <= '0;
                r_fire  <= 1'b0;
            end else begin
                r_fire <= 1'b0;
                if (w_lock_all) begin
                    r_state <= LOCK;
                    r_timer <= '0;
                end else begin
                    case (r_state)
                        IDLE: if (w_press[g+1]) begin
                            r_fire  <= 1'b1;
                            r_state <= HOLD;
                            r_timer <= '0;
                        end
                        HOLD: if (w_stable[g+1]) begin
                            r_state <= IDLE;
                            r_timer <= '0;
                        end else if (r_timer == HOLD_LAST) begin
                            r_fire  <= 1'b1;
                            r_state <= REPEAT;
                            r_timer <= '0;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                        REPEAT: if (w_stable[g+1]) begin
                            r_state <= IDLE;
                            r_timer <= '0;
                        end else if (r_timer == REP_LAST) begin
                            r_fire  <= 1'b1;
                            r_timer <= '0;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                        LOCK: if (w_stable[g+1]) begin
                            r_state <= IDLE;
                            r_timer <= '0;
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end

        assign w_fire[g] = r_fire;
    end

    // Strobes cannot coincide: a strobe needs its key held, and both
    // held forces LOCK.
    assign bus.mode_cnt = r_mode_cnt;
    assign bus.key_inc  = w_fire[0];
    assign bus.key_dec  = w_fire[1];

endmodule

// File: tb/tb_key_mode_ctrl.sv
module tb_key_mode_ctrl;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    key_mode_ctrl_if bus ();

    key_mode_ctrl #(
        .DEB_CYCLES    (4),
        .HOLD_CYCLES   (20),
        .REPEAT_CYCLES (8)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // kind: 1 = key_inc, 2 = key_dec, 3 = mode_cnt change (val = new value)
    typedef struct {
        int kind;
        int at;
        int val;
    } ev_t;

    ev_t        sb[$];
    int         n_cmp    = 0;
    int         n_bad    = 0;
    int         exp_mode = 0;
    logic [1:0] prev_mode = 2'd0;
    bit         mon_en   = 1'b0;
    int         c;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d exp %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int at, input int val);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic got_ev(input int kind, input int val);
        ev_t e;
        if (sb.size() == 0) begin
            chk("unexpected_event_kind", kind, 0);
        end else begin
            e = sb.pop_front();
            chk("ev_kind", kind, e.kind);
            chk("ev_cycle", cyc, e.at);
            if (kind == 3) chk("mode_val", val, e.val);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Output monitor: every observed strobe / mode change is matched
    // against the head of the scoreboard.
    always @(negedge sys_clk) begin
        if (mon_en && sys_rst_n) begin
            if (bus.key_inc && bus.key_dec) chk("inc_dec_excl", 1, 0);
            if (bus.key_inc) got_ev(1, 0);
            if (bus.key_dec) got_ev(2, 0);
            if (bus.mode_cnt != prev_mode) got_ev(3, int'(bus.mode_cnt));
        end
        prev_mode = bus.mode_cnt;
    end

    initial begin
        bus.key_mode_n = 1'b1;
        bus.key_up_n   = 1'b1;
        bus.key_down_n = 1'b1;
        tick(3);
        chk("rst_mode", int'(bus.mode_cnt), 0);
        chk("rst_inc",  int'(bus.key_inc), 0);
        chk("rst_dec",  int'(bus.key_dec), 0);
        sys_rst_n = 1'b1;
        mon_en    = 1'b1;

        // idle
        tick(100);
        chk("idle_mode", int'(bus.mode_cnt), 0);
        chk("idle_sb", sb.size(), 0);

        // bouncing up key, then a clean press
        for (int i = 0; i < 6; i++) begin
            bus.key_up_n = i[0];
            tick(2);
        end
        c = cyc;
        bus.key_up_n = 1'b0;
        push(1, c + 7, 0);
        tick(10);
        bus.key_up_n = 1'b1;
        tick(20);
        chk("bounce_sb", sb.size(), 0);

        // five mode presses, wrapping 3 -> 0
        for (int i = 0; i < 5; i++) begin
            c = cyc;
            bus.key_mode_n = 1'b0;
            exp_mode = (exp_mode + 1) % 4;
            push(3, c + 7, exp_mode);
            tick(8);
            bus.key_mode_n = 1'b1;
            tick(12);
        end
        chk("mode_final", int'(bus.mode_cnt), 1);
        chk("mode_sb", sb.size(), 0);

        // auto-repeat: P, P+20, P+28, P+36, P+44, P+52
        c = cyc;
        bus.key_up_n = 1'b0;
        push(1, c + 7, 0);
        for (int k = 0; k < 5; k++) push(1, c + 27 + 8 * k, 0);
        tick(57);                     // release at P+50
        bus.key_up_n = 1'b1;
        tick(30);
        chk("repeat_sb", sb.size(), 0);

        // both held: nothing; up held alone after down release: still locked
        bus.key_up_n   = 1'b0;
        bus.key_down_n = 1'b0;
        tick(20);
        bus.key_down_n = 1'b1;
        tick(50);
        bus.key_up_n = 1'b1;
        tick(20);
        chk("both_sb", sb.size(), 0);
        c = cyc;
        bus.key_up_n = 1'b0;
        push(1, c + 7, 0);
        tick(10);
        bus.key_up_n = 1'b1;
        tick(30);
        chk("relock_sb", sb.size(), 0);

        // mode press during a down hold cancels repeats
        c = cyc;
        bus.key_down_n = 1'b0;
        push(2, c + 7, 0);
        tick(15);
        bus.key_mode_n = 1'b0;
        exp_mode = (exp_mode + 1) % 4;
        push(3, c + 22, exp_mode);
        tick(8);
        bus.key_mode_n = 1'b1;
        tick(60);
        chk("modelock_mode", int'(bus.mode_cnt), 2);
        bus.key_down_n = 1'b1;
        tick(20);
        chk("modelock_sb", sb.size(), 0);

        // reset mid-hold, key kept down through reset
        c = cyc;
        bus.key_down_n = 1'b0;
        push(2, c + 7, 0);
        tick(17);
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_mode", int'(bus.mode_cnt), 0);
        chk("midrst_inc",  int'(bus.key_inc), 0);
        chk("midrst_dec",  int'(bus.key_dec), 0);
        exp_mode = 0;
        tick(3);
        sys_rst_n = 1'b1;
        c = cyc;
        push(2, c + 7, 0);
        tick(12);
        bus.key_down_n = 1'b1;
        tick(30);
        chk("rst_sb", sb.size(), 0);
        chk("end_mode", int'(bus.mode_cnt), exp_mode);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
